// File: rtl/mdu_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one result bit per cycle over WORD_WIDTH iterations.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module mdu_seq_ctrl #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            operator_i,
    input  logic [WORD_WIDTH-1:0] operand_a_i,
    input  logic [WORD_WIDTH-1:0] operand_b_i,
    input  logic                  kill_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [WORD_WIDTH-1:0] result_o
);
    // state | meaning
    // IDLE  | waiting for start_i; operands latched on acceptance
    // BUSY  | one shift-add / restoring-divide step per cycle, iter_cnt 0..31
    // DONE  | result_o freshly updated, valid_o pulses unless killed
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         W         = WORD_WIDTH;
    localparam logic [4:0] LAST_ITER = 5'(W - 1);

    state_t           state_q, state_d;
    logic [4:0]       iter_cnt;
    logic [2:0]       op_q;
    logic [2*W-1:0]   acc_q, acc_nx;
    logic [W-1:0]     opnd_q;
    logic             neg_q, div_zero_q;
    logic [W-1:0]     result_q;
    logic             load, step, finish;

    logic             a_signed, b_signed, a_neg, b_neg, neg_in, div_zero_in;
    logic [W-1:0]     a_mag, b_mag;

    assign a_signed    = operator_i[2] ? ~operator_i[0] : (operator_i[1:0] != 2'b11);
    assign b_signed    = operator_i[2] ? ~operator_i[0] : ~operator_i[1];
    assign a_neg       = a_signed & operand_a_i[W-1];
    assign b_neg       = b_signed & operand_b_i[W-1];
    assign a_mag       = a_neg ? -operand_a_i : operand_a_i;
    assign b_mag       = b_neg ? -operand_b_i : operand_b_i;
    assign div_zero_in = operator_i[2] & (operand_b_i == '0);
    // Remainder follows the dividend sign; product and quotient follow the sign difference.
    assign neg_in      = (operator_i[2] & operator_i[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_EARLY_OUT_EN
    logic         ovf_in, early_hit, early_done;
    logic [W-1:0] early_res;

    assign ovf_in    = operator_i[2] & ~operator_i[0] &
                       (operand_a_i == {1'b1, {(W-1){1'b0}}}) & (operand_b_i == '1);
    assign early_hit = div_zero_in | ovf_in;
    assign early_res = operator_i[1] ? (div_zero_in ? operand_a_i : '0)
                                     : (div_zero_in ? '1 : operand_a_i);
`endif

    logic [W:0]     mul_sum, rem_shift, trial;
    logic           q_bit;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        trial     = rem_shift - {1'b0, opnd_q};
        q_bit     = ~trial[W];
        if (op_q[2])
            acc_nx = {(q_bit ? trial[W-1:0] : rem_shift[W-1:0]), acc_q[W-2:0], q_bit};
        else
            acc_nx = {mul_sum, acc_q[W-1:1]};

        prod = neg_q ? -acc_nx : acc_nx;
        quo  = acc_nx[W-1:0];
        rem  = acc_nx[2*W-1:W];
        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (op_q[1])
            final_res = neg_q ? -rem : rem;
        else if (div_zero_q)
            final_res = '1;
        else
            final_res = neg_q ? -quo : quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
`ifdef MDU_EARLY_OUT_EN
        early_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
`ifdef MDU_EARLY_OUT_EN
                    if (early_hit) begin
                        state_d    = DONE;
                        early_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                        load    = 1'b1;
                    end
`else
                    state_d = BUSY;
                    load    = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt   <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            if (load) begin
                iter_cnt   <= '0;
                op_q       <= operator_i;
                acc_q      <= {{W{1'b0}}, (operator_i[2] ? a_mag : b_mag)};
                opnd_q     <= operator_i[2] ? b_mag : a_mag;
                neg_q      <= neg_in;
                div_zero_q <= div_zero_in;
            end else if (step) begin
                iter_cnt <= iter_cnt + 5'd1;
                acc_q    <= acc_nx;
            end
            if (finish)
                result_q <= final_res;
`ifdef MDU_EARLY_OUT_EN
            else if (early_done)
                result_q <= early_res;
`endif
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE) && !kill_i;
    assign stall_o  = ((state_q == IDLE) && start_i && !kill_i) || (state_q == BUSY);
    assign result_o = result_q;

endmodule

// File: doc/mdu_seq_ctrl.md
MDU_SEQ_CTRL -- requirements
Module: mdu_seq_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request to start an operation, sampled on clk.
REQ-005 operator_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_a_i  input  WORD_WIDTH  rs1 value (multiplicand/dividend).
REQ-007 operand_b_i  input  WORD_WIDTH  rs2 value (multiplier/divisor).
REQ-008 kill_i  input  1  pipeline flush; aborts the current or requested operation.
REQ-009 stall_o  output  1  holds the EX stage while an operation is pending.
REQ-010 busy_o  output  1  state is not IDLE.
REQ-011 valid_o  output  1  result_o valid this cycle; one-cycle pulse.
REQ-012 result_o  output  WORD_WIDTH  last completed result.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE->BUSY on start_i=1 and kill_i=0; operator and operands are latched at that edge.
REQ-015 Later changes on the operator and operand inputs SHALL NOT affect the operation in flight.
REQ-016 BUSY SHALL run exactly WORD_WIDTH iterations, one result bit per cycle, using a 5-bit counter 0..31; at count 31 the state goes to DONE.
REQ-017 DONE SHALL last one cycle, then return to IDLE; start_i is ignored in BUSY and DONE.
REQ-018 Latency: start accepted at edge N -> valid_o high during cycle N+33.
REQ-019 valid_o = (state==DONE) and not kill_i.
REQ-020 result_o SHALL update at entry to DONE and hold until the next completion.
REQ-021 stall_o = (IDLE and start_i and not kill_i) or BUSY; it SHALL be low in DONE.
REQ-022 Multiply: shift-add on operand magnitudes into a 2*WORD_WIDTH product.
REQ-023 Multiply sign: negate the product when the operand signs differ (signedness per op; MULHSU has a signed, b unsigned).
REQ-024 Multiply select: MUL returns low word; MULH/MULHSU/MULHU return high word.
REQ-025 Divide: restoring division on magnitudes.
REQ-026 Divide sign: negate the quotient if the signs differ (DIV); the remainder takes the dividend sign (REM).
REQ-027 Divide by zero SHALL give quotient all-ones and remainder = dividend, for signed and unsigned ops.
REQ-028 Signed overflow (0x80000000 / -1) SHALL give quotient 0x80000000 and remainder 0.
REQ-029 kill_i in BUSY or DONE SHALL return the FSM to IDLE at the next edge with no valid_o and result_o unchanged.
REQ-030 kill_i and start_i together in IDLE: kill wins and the start is not accepted.

Reset
REQ-031 While rst_n=0: state IDLE, counter 0, internal registers 0.
REQ-032 While rst_n=0: result_o 0, valid_o 0, busy_o 0, stall_o follows REQ-021.
REQ-033 Reset asserted mid-operation SHALL abort immediately with no valid_o.
REQ-034 After release, the first start is accepted on the first rising edge.

Configuration
REQ-035 Macro MDU_EARLY_OUT_EN defined: divide by zero and signed overflow SHALL go IDLE->DONE directly, with valid_o in cycle N+1.
REQ-036 Macro MDU_EARLY_OUT_EN undefined: these cases SHALL run the full 32 iterations (valid_o at N+33).
REQ-037 Result values SHALL be identical with and without MDU_EARLY_OUT_EN.

Verification
REQ-038 MUL 7 x 0xFFFFFFFD, start at N -> result_o 0xFFFFFFEB, valid_o high only in cycle N+33, stall_o high N..N+32.
REQ-039 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-040 MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-041 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-043 DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100; valid_o at N+1 with MDU_EARLY_OUT_EN, at N+33 without.
REQ-044 kill_i at BUSY iteration 10 -> IDLE next cycle, no valid_o, result_o unchanged; a new MUL 3x5 started next -> 15 at +33.
REQ-045 rst_n low at iteration 20 -> outputs at reset values asynchronously, no valid_o; a start after release completes normally.
REQ-046 start_i held high through BUSY -> exactly one operation completes; a new start is accepted in the cycle after DONE.
